// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - led_fader shared helpers; LED_FADER_GAMMA_EN adds the gamma curve.
package led_fader_pkg;

    // Widths up to 32 bits; the sum is held one bit wider so it never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

`ifdef LED_FADER_GAMMA_EN
    function automatic logic [31:0] gamma(input logic [31:0] d, input int w);
        logic [63:0] p;
        p = {32'd0, d} * {32'd0, d};
        return 32'(p >> w);
    endfunction
`endif

endpackage

// File: rtl/led_fader_chan.sv
// rtl/led_fader_chan.sv - one LED channel: duty ramp and PWM compare; LED_FADER_GAMMA_EN selects gamma.
module led_fader_chan
    import led_fader_pkg::*;
#(
    parameter int DUTY_W = 6,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic              next_tgt,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic              led
);

    localparam logic [DUTY_W-1:0] DMAX = '1;

    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W-1:0] eff;

    always_comb begin
        duty_nxt = duty;
        if (next_tgt)
            duty_nxt = DUTY_W'(sat_add(32'(duty), 32'(STEP), DUTY_W));
        else
            duty_nxt = DUTY_W'(sat_sub(32'(duty), 32'(STEP)));
    end

`ifdef LED_FADER_GAMMA_EN
    assign eff = DUTY_W'(gamma(32'(duty), DUTY_W));
`else
    assign eff = duty;
`endif

    // Full duty is forced solid on; the compare alone would leave one dark tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            led  <= 1'b0;
        end else begin
            if (boundary)
                duty <= duty_nxt;
            led <= (duty == DMAX) || (pwm_cnt < eff);
        end
    end

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED fader top: prescaler, PWM counter, pattern handshake; LED_FADER_GAMMA_EN in channels.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int N_LEDS = 5,
    parameter int DUTY_W = 6,
    parameter int PRESC  = 16,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] pat_in,
    input  logic              pat_valid,
    output logic              pat_ready,
    output logic [N_LEDS-1:0] led,
    output logic              period_start
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0]     presc_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              tick;
    logic              boundary;
    logic              xfer;
    logic              pending;
    logic [N_LEDS-1:0] pend_pat;
    logic [N_LEDS-1:0] target;
    logic [N_LEDS-1:0] next_target;

    assign tick        = (presc_cnt == PRESC_LAST);
    assign boundary    = tick && (pwm_cnt == {DUTY_W{1'b1}});
    assign pat_ready   = !pending && !rst;
    assign xfer        = pat_valid && pat_ready;
    assign next_target = pending ? pend_pat : target;

    // A transfer landing on a boundary stays pending for the following one.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            target       <= '0;
            pend_pat     <= '0;
            pending      <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            period_start <= boundary;
            if (boundary) begin
                target  <= next_target;
                pending <= 1'b0;
            end
            if (xfer) begin
                pend_pat <= pat_in;
                pending  <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        led_fader_chan #(
            .DUTY_W (DUTY_W),
            .STEP   (STEP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .boundary (boundary),
            .next_tgt (next_target[i]),
            .pwm_cnt  (pwm_cnt),
            .led      (led[i])
        );
    end

endmodule
